// File: rtl/monmul_rt_if.sv
// Start/operand/result bundle between a Montgomery multiplier and its controller.
interface monmul_rt_if #(
  parameter int K = 8
);
  logic         start;
  logic [K-1:0] x;
  logic [K-1:0] y;
  logic [K-1:0] m;
  logic [K:0]   z;
  logic         busy;
  logic         done;
  logic         err;

  modport master (output start, x, y, m, input z, busy, done, err);
  modport slave  (input start, x, y, m, output z, busy, done, err);
endinterface

// File: rtl/monmul_rt.sv
// Radix-2 bit-serial Montgomery multiplier z = x*y*2^-K mod m with run-time odd modulus.
// Define MONMUL_FINAL_SUB_EN to fully reduce z below m; otherwise z is left in [0, 2m).
module monmul_rt #(
  parameter int K = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  monmul_rt_if.slave bus
);
  localparam int CW = $clog2(K) + 1;
  localparam int SW = K + 2;

  typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;

  state_t        state_q, state_d;
  logic [K-1:0]  x_q, x_d;
  logic [K-1:0]  y_q, y_d;
  logic [K-1:0]  m_q, m_d;
  logic [SW-1:0] s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [K:0]    z_q, z_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // One iteration: add the selected multiple of y, make the sum even with q*m, halve.
  function automatic logic [SW-1:0] mont_step(input logic [SW-1:0] s, input logic xb,
                                              input logic [K-1:0] y, input logic [K-1:0] m);
    logic [SW:0] acc;
    acc = {1'b0, s} + (xb ? {{(SW + 1 - K){1'b0}}, y} : '0);
    if (acc[0]) acc = acc + {{(SW + 1 - K){1'b0}}, m};
    return acc[SW:1];
  endfunction

`ifdef MONMUL_FINAL_SUB_EN
  function automatic logic [K:0] final_fix(input logic [SW-1:0] s, input logic [K-1:0] m);
    logic [K:0] d;
    d = s[K:0] - {1'b0, m};
    return (s >= {2'b00, m}) ? d : s[K:0];
  endfunction
`else
  function automatic logic [K:0] final_fix(input logic [K:0] s);
    return s;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    m_d     = m_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.x;
          y_d     = bus.y;
          m_d     = bus.m;
          s_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          // An even modulus skips the iterations but still spends one cycle in FIX.
          state_d = bus.m[0] ? CALC : FIX;
        end
      end
      CALC: begin
        s_d   = mont_step(s_q, x_q[0], y_q, m_q);
        x_d   = x_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) state_d = FIX;
      end
      FIX: begin
`ifdef MONMUL_FINAL_SUB_EN
        z_d = m_q[0] ? final_fix(s_q, m_q) : '0;
`else
        z_d = m_q[0] ? final_fix(s_q[K:0]) : '0;
`endif
        err_d   = ~m_q[0];
        done_d  = 1'b1;
        state_d = FIN;
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
    m_q <= m_d;
  end

  assign bus.z    = z_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_monmul_rt.sv
// Randomized bench for monmul_rt (K=8 and K=16 instances) against a modular-arithmetic reference.
module tb_monmul_rt;
  logic clk = 1'b0;
  logic reset_n;

  monmul_rt_if #(.K(8))  b8 ();
  monmul_rt_if #(.K(16)) b16 ();

  monmul_rt #(.K(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(b8));
  monmul_rt #(.K(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(b16));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  longint inv8, inv16;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inverse of 2^k modulo m by exhaustive search.
  function automatic longint rinv(input longint m, input int k);
    longint r;
    r = (longint'(1) << k) % m;
    for (longint i = 1; i < m; i++)
      if ((r * i) % m == 1) return i;
    return 0;
  endfunction

  function automatic longint ref_mont(input longint x, input longint y, input longint m,
                                      input longint inv);
    return (((x * y) % m) * inv) % m;
  endfunction

  // Issue one start, scramble inputs after accept, wait for done, then for the return to idle.
  task automatic do_op(input bit big, input longint xv, input longint yv, input longint mv,
                       output longint zv, output bit ev, output int lat, output bit bsy);
    @(negedge clk);
    if (big) begin
      b16.start = 1'b1; b16.x = 16'(xv); b16.y = 16'(yv); b16.m = 16'(mv);
    end else begin
      b8.start = 1'b1; b8.x = 8'(xv); b8.y = 8'(yv); b8.m = 8'(mv);
    end
    @(posedge clk);
    #1;
    if (big) begin
      b16.start = 1'b0; b16.x = 16'($urandom); b16.y = 16'($urandom); b16.m = 16'($urandom);
    end else begin
      b8.start = 1'b0; b8.x = 8'($urandom); b8.y = 8'($urandom); b8.m = 8'($urandom);
    end
    lat = -1; zv = 0; ev = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (big ? b16.done : b8.done) begin
        lat = i;
        zv  = big ? longint'(b16.z) : longint'(b8.z);
        ev  = big ? b16.err : b8.err;
        break;
      end
    end
    @(posedge clk);
    #1;
    bsy = big ? b16.busy : b8.busy;
  endtask

  task automatic verify_op(input string tag, input bit big, input longint xv, input longint yv,
                           input longint mv);
    longint zv, exp;
    bit ev, bsy;
    int lat, k;
    k = big ? 16 : 8;
    do_op(big, xv, yv, mv, zv, ev, lat, bsy);
    check({tag, "_busy_after"}, 64'(bsy), 64'(0));
    if (mv % 2 == 0) begin
      check({tag, "_lat"}, 64'(lat), 64'(1));
      check({tag, "_err"}, 64'(ev), 64'(1));
      check({tag, "_z"}, 64'(zv), 64'(0));
    end else begin
      exp = ref_mont(xv, yv, mv, big ? inv16 : inv8);
      check({tag, "_lat"}, 64'(lat), 64'(k + 1));
      check({tag, "_err"}, 64'(ev), 64'(0));
`ifdef MONMUL_FINAL_SUB_EN
      check({tag, "_z"}, 64'(zv), 64'(exp));
`else
      check({tag, "_zmod"}, 64'(zv % mv), 64'(exp));
      check({tag, "_zrange"}, 64'(zv < 2 * mv), 64'(1));
`endif
    end
  endtask

  initial begin
    longint xs [0:39];
    int last_done, ndone;
    longint hz;

    inv8  = rinv(239, 8);
    inv16 = rinv(65521, 16);
    reset_n = 1'b0;
    b8.start = 1'b0;  b8.x = '0;  b8.y = '0;  b8.m = '0;
    b16.start = 1'b0; b16.x = '0; b16.y = '0; b16.m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_z", 64'(b8.z), 64'(0));
    check("rst_busy", 64'(b8.busy), 64'(0));
    check("rst_done", 64'(b8.done), 64'(0));
    check("rst_err", 64'(b8.err), 64'(0));
    check("rst_z16", 64'(b16.z), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    check("ref_sanity", 64'(ref_mont(202, 236, 239, inv8)), 64'(119));
    verify_op("dir_202_236", 1'b0, 202, 236, 239);
    verify_op("dir_1_1", 1'b0, 1, 1, 239);
    verify_op("dir_0_200", 1'b0, 0, 200, 239);
    verify_op("dir_238_238", 1'b0, 238, 238, 239);
    for (int i = 0; i < 1000; i++)
      verify_op("rnd8", 1'b0, longint'($urandom_range(238, 0)), longint'($urandom_range(238, 0)), 239);

    verify_op("dir16_1_1", 1'b1, 1, 1, 65521);
    verify_op("dir16_max", 1'b1, 65520, 65520, 65521);
    for (int i = 0; i < 500; i++)
      verify_op("rnd16", 1'b1, longint'($urandom_range(65520, 0)),
                longint'($urandom_range(65520, 0)), 65521);

    verify_op("even_m", 1'b0, 5, 7, 240);
    verify_op("after_even", 1'b0, 202, 236, 239);

    // start held high with x changing every cycle: each accept must use its own x
    last_done = -1;
    ndone = 0;
    b8.y = 8'd236;
    b8.m = 8'd239;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      xs[n] = longint'($urandom_range(238, 0));
      b8.x = 8'(xs[n]);
      b8.start = 1'b1;
      @(posedge clk);
      #1;
      if (b8.done) begin
        ndone++;
        if (last_done >= 0) check("hold_gap", 64'(n - last_done), 64'(11));
        else check("hold_first", 64'(n), 64'(9));
        last_done = n;
        hz = (n >= 9) ? ref_mont(xs[n - 9], 236, 239, inv8) : -1;
        check("hold_zmod", 64'(longint'(b8.z) % 239), 64'(hz));
      end
    end
    check("hold_count", 64'(ndone), 64'(3));
    @(negedge clk);
    b8.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;

    // asynchronous reset in the middle of CALC
    verify_op("pre_rst", 1'b0, 202, 236, 239);
    @(negedge clk);
    b8.start = 1'b1; b8.x = 8'd202; b8.y = 8'd236; b8.m = 8'd239;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_z", 64'(b8.z), 64'(0));
    check("arst_busy", 64'(b8.busy), 64'(0));
    check("arst_done", 64'(b8.done), 64'(0));
    check("arst_err", 64'(b8.err), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    verify_op("post_rst", 1'b0, 202, 236, 239);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
